// File: rtl/reg_port_arbiter_pkg.sv
// Shared constants, FSM encoding and request record for the register-file port arbiter.
package reg_port_arbiter_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_NUM_REGS = 8;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t SWEEP = 2'd1;
  localparam arb_state_t DONE  = 2'd2;

  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] wdata;
  } rf_req_t;

endpackage

// File: rtl/reg_port_arbiter_if.sv
// Two-port request/response bundle between the requesters and the register-file arbiter.
interface reg_port_arbiter_if
  import reg_port_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) ();

  logic [1:0]             req_valid;
  logic [1:0]             req_we;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             req_ready;
  logic [1:0]             rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/reg_port_arbiter_rr_arb2.sv
// Combinational two-way grant: fixed priority to port 0, or round-robin against the last winner.
module reg_port_arbiter_rr_arb2 #(
  parameter bit FIXED_P0 = 1'b0
) (
  input  logic [1:0] valid,
  input  logic       rr_last,
  input  logic       en,
  output logic [1:0] grant
);

  // rr_last=1 means port 1 won last time, so port 0 has the turn on a tie.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid[0] && (!valid[1] || FIXED_P0 || rr_last))
        grant = 2'b01;
      else if (valid[1])
        grant = 2'b10;
    end
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Shares the register file's write port and SR1 read port between two requesters and runs a clear sweep.
module reg_port_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter bit FIXED_P0 = 1'b0
) (
  input  logic                Clk,
  input  logic                Reset_al,
  reg_port_arbiter_if.slave   bus,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                rf_ld,
  output logic [ADDR_W-1:0]   rf_dr,
  output logic [ADDR_W-1:0]   rf_sr1,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic [DATA_W-1:0]   rf_rdata
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  arb_state_t        state;
  logic [ADDR_W-1:0] idx;
  logic              rr_last;
  logic [1:0]        grant;
  logic              arb_en;
  rf_req_t           sel;
  logic              vld_p1;
  logic              port_p1;

  // A pending clear wins over any request in the same cycle.
  assign arb_en = Reset_al && (state == IDLE) && !clr_req;

  reg_port_arbiter_rr_arb2 #(
    .FIXED_P0 (FIXED_P0)
  ) u_arb (
    .valid   (bus.req_valid),
    .rr_last (rr_last),
    .en      (arb_en),
    .grant   (grant)
  );

  assign bus.req_ready = grant;
  assign clr_busy      = (state == SWEEP);
  assign clr_done      = (state == DONE);

  always_comb begin
    sel.we    = grant[1] ? bus.req_we[1]    : bus.req_we[0];
    sel.addr  = grant[1] ? bus.req_addr[1]  : bus.req_addr[0];
    sel.wdata = grant[1] ? bus.req_wdata[1] : bus.req_wdata[0];
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state   <= IDLE;
      idx     <= '0;
      rr_last <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= SWEEP;
            idx   <= '0;
          end else if (|grant) begin
            rr_last <= grant[1];
          end
        end
        SWEEP: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: register-file command, one cycle after accept or sweep issue.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      rf_ld    <= 1'b0;
      rf_dr    <= '0;
      rf_sr1   <= '0;
      rf_wdata <= '0;
      vld_p1   <= 1'b0;
      port_p1  <= 1'b0;
    end else begin
      rf_ld   <= 1'b0;
      vld_p1  <= (|grant) && !sel.we;
      port_p1 <= grant[1];
      if (state == SWEEP) begin
        rf_ld    <= 1'b1;
        rf_dr    <= idx;
        rf_wdata <= '0;
      end else if (|grant) begin
        rf_ld    <= sel.we;
        rf_dr    <= sel.addr;
        rf_sr1   <= sel.addr;
        rf_wdata <= sel.wdata;
      end
    end
  end

  // Stage p2: read response, rf_rdata sampled while rf_sr1 holds the read address.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      bus.rsp_valid <= 2'b00;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= vld_p1 ? (port_p1 ? 2'b10 : 2'b01) : 2'b00;
      if (vld_p1)
        bus.rsp_rdata <= rf_rdata;
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with a behavioural 8x16 register file on the rf_* port.
module tb_reg_port_arbiter;
  import reg_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr_req;
  logic        clr_busy, clr_done, rf_ld;
  logic [2:0]  rf_dr, rf_sr1;
  logic [15:0] rf_wdata, rf_rdata;

  logic        clr_busy_fx, clr_done_fx, rf_ld_fx;
  logic [2:0]  rf_dr_fx, rf_sr1_fx;
  logic [15:0] rf_wdata_fx;
  logic [15:0] rf_rdata_fx;
  assign rf_rdata_fx = 16'h0000;

  reg_port_arbiter_if bus ();
  reg_port_arbiter_if bus_fx ();

  reg_port_arbiter #(.FIXED_P0(1'b0)) dut (
    .Clk (clk), .Reset_al (rst_n), .bus (bus), .clr_req (clr_req),
    .clr_busy (clr_busy), .clr_done (clr_done), .rf_ld (rf_ld), .rf_dr (rf_dr),
    .rf_sr1 (rf_sr1), .rf_wdata (rf_wdata), .rf_rdata (rf_rdata)
  );

  reg_port_arbiter #(.FIXED_P0(1'b1)) dut_fx (
    .Clk (clk), .Reset_al (rst_n), .bus (bus_fx), .clr_req (clr_req),
    .clr_busy (clr_busy_fx), .clr_done (clr_done_fx), .rf_ld (rf_ld_fx), .rf_dr (rf_dr_fx),
    .rf_sr1 (rf_sr1_fx), .rf_wdata (rf_wdata_fx), .rf_rdata (rf_rdata_fx)
  );

  logic [15:0] regs [8];
  always @(posedge clk) if (rf_ld) regs[rf_dr] <= rf_wdata;
  assign rf_rdata = regs[rf_sr1];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [15:0] w0, input logic [15:0] w1);
    bus.req_valid = v;       bus_fx.req_valid = v;
    bus.req_we    = we;      bus_fx.req_we    = we;
    bus.req_addr[0] = a0;    bus_fx.req_addr[0] = a0;
    bus.req_addr[1] = a1;    bus_fx.req_addr[1] = a1;
    bus.req_wdata[0] = w0;   bus_fx.req_wdata[0] = w0;
    bus.req_wdata[1] = w1;   bus_fx.req_wdata[1] = w1;
    #1;
  endtask

  initial begin
    clr_req = 1'b0;
    drive(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);

    // Reset state
    chk("rst_rf_ld", rf_ld, 0);
    chk("rst_rf_dr", rf_dr, 0);
    chk("rst_rf_sr1", rf_sr1, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Both ports requesting every cycle: round-robin alternates, fixed priority starves port 1
    drive(2'b11, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("fx_grant", bus_fx.req_ready, 2'b01);
      tick();
    end
    drive(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
    tick();
    tick();
    tick();

    // Port 0 writes R3 then reads it back
    drive(2'b01, 2'b01, 3'd3, 3'd0, 16'hBEEF, 16'h0);
    chk("t1_wr_ready", bus.req_ready, 2'b01);
    tick();
    drive(2'b01, 2'b00, 3'd3, 3'd0, 16'h0, 16'h0);
    chk("t1_rf_ld", rf_ld, 1);
    chk("t1_rf_dr", rf_dr, 3);
    chk("t1_rf_wdata", rf_wdata, 16'hBEEF);
    chk("t1_rd_ready", bus.req_ready, 2'b01);
    tick();
    drive(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
    chk("t1_rd_rf_ld", rf_ld, 0);
    chk("t1_rf_sr1", rf_sr1, 3);
    chk("t1_no_rsp_yet", bus.rsp_valid, 2'b00);
    tick();
    chk("t1_rsp_valid", bus.rsp_valid, 2'b01);
    chk("t1_rsp_rdata", bus.rsp_rdata, 16'hBEEF);
    tick();
    chk("t1_rsp_pulse", bus.rsp_valid, 2'b00);

    // Port 1 writes R5, port 0 reads it on the very next accept
    drive(2'b10, 2'b10, 3'd0, 3'd5, 16'h0, 16'h1234);
    chk("t3_wr_ready", bus.req_ready, 2'b10);
    tick();
    drive(2'b01, 2'b00, 3'd5, 3'd0, 16'h0, 16'h0);
    chk("t3_rd_ready", bus.req_ready, 2'b01);
    tick();
    drive(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
    tick();
    chk("t3_rsp_valid", bus.rsp_valid, 2'b01);
    chk("t3_rsp_rdata", bus.rsp_rdata, 16'h1234);
    tick();
    chk("t3_rsp_off", bus.rsp_valid, 2'b00);
    chk("t3_rdata_hold", bus.rsp_rdata, 16'h1234);

    // Preload R0..R7 back-to-back through port 1
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, 2'b10, 3'd0, 3'(i), 16'h0, 16'(16'h1111 * i + 1));
      chk("pre_ready", bus.req_ready, 2'b10);
      tick();
    end

    // Port 0 read of R2 accepted the cycle before the clear request
    drive(2'b01, 2'b00, 3'd2, 3'd0, 16'h0, 16'h0);
    chk("t6_rd_ready", bus.req_ready, 2'b01);
    tick();

    // Clear sweep with both ports requesting throughout
    clr_req = 1'b1;
    drive(2'b11, 2'b00, 3'd7, 3'd4, 16'h0, 16'h0);
    for (int k = 0; k < 10; k++) begin
      chk("sw_ready", bus.req_ready, 2'b00);
      chk("sw_busy", clr_busy, (k >= 1 && k <= 8) ? 1 : 0);
      chk("sw_done", clr_done, (k == 9) ? 1 : 0);
      chk("sw_rf_ld", rf_ld, (k >= 2) ? 1 : 0);
      if (k >= 2) begin
        chk("sw_rf_dr", rf_dr, k - 2);
        chk("sw_rf_wdata", rf_wdata, 0);
      end
      if (k == 1) begin
        chk("t6_rsp_valid", bus.rsp_valid, 2'b01);
        chk("t6_rsp_rdata", bus.rsp_rdata, 16'h2223);
      end
      tick();
      if (k == 0) clr_req = 1'b0;
    end
    chk("post_ready_p1", bus.req_ready, 2'b10);
    chk("post_done", clr_done, 0);
    chk("post_busy", clr_busy, 0);
    tick();
    drive(2'b01, 2'b00, 3'd7, 3'd4, 16'h0, 16'h0);
    chk("post_ready_p0", bus.req_ready, 2'b01);
    tick();
    drive(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
    chk("clr_rsp_p1", bus.rsp_valid, 2'b10);
    chk("clr_rdata_r4", bus.rsp_rdata, 16'h0000);
    tick();
    chk("clr_rsp_p0", bus.rsp_valid, 2'b01);
    chk("clr_rdata_r7", bus.rsp_rdata, 16'h0000);
    tick();

    // Reset asserted at sweep index 4
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_pre_busy", clr_busy, 1);
    chk("t5_pre_rf_dr", rf_dr, 3);
    drive(2'b11, 2'b00, 3'd1, 3'd1, 16'h0, 16'h0);
    rst_n = 1'b0;
    #1;
    chk("t5_rf_ld", rf_ld, 0);
    chk("t5_rf_dr", rf_dr, 0);
    chk("t5_rf_wdata", rf_wdata, 0);
    chk("t5_busy", clr_busy, 0);
    chk("t5_done", clr_done, 0);
    chk("t5_ready", bus.req_ready, 2'b00);
    chk("t5_rsp_rdata", bus.rsp_rdata, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_idle_grant", bus.req_ready, 2'b01);
    tick();
    drive(2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_done", clr_done, 0);
      chk("t5_no_busy", clr_busy, 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
